// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle for the execute-stage ALU with mul/div.
//   master : drives valid_in, func_code, a, b; observes ready_out and the result side
//   slave  : the ALU itself; drives ready_out, valid_out, result, zero, overflow,
//            illegal, hi, lo
interface alu_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [5:0]       func_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid_out;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output valid_in, func_code, a, b,
    input  ready_out, valid_out, result, zero, overflow, illegal, hi, lo
  );

  modport slave (
    input  valid_in, func_code, a, b,
    output ready_out, valid_out, result, zero, overflow, illegal, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: R-type ALU with registered result/flags and an iterative
// multiply/divide unit owning the architectural HI/LO registers.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of alu_muldiv_if (request a/b/func_code with
//                valid_in/ready_out, registered result/flags with a one-cycle
//                valid_out pulse, HI/LO always visible)
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_muldiv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd_q;    // multiplicand / divisor magnitude
  logic                 neg_q;     // negate product / quotient at the end
  logic                 negr_q;    // negate remainder at the end
  logic                 div0_q;
  logic                 is_mul_q;
  logic                 valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic                 ovf_q;
  logic                 ill_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 accept;
  logic                 sgn;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     sum_d;
  logic [WIDTH-1:0]     dif_d;
  logic [WIDTH-1:0]     alu_res_d;
  logic                 alu_ovf_d;
  logic                 alu_ill_d;
  logic                 wr_hi_d;
  logic                 wr_lo_d;
  logic                 start_mul_d;
  logic                 start_div_d;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       div_cand;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     fin_hi_d;
  logic [WIDTH-1:0]     fin_lo_d;

  assign accept        = bus.valid_in && (state_q == S_IDLE);
  assign bus.ready_out = (state_q == S_IDLE);
  assign bus.valid_out = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // Signed variants (MULT, DIV) have func_code[0] clear.
  assign sgn   = ~bus.func_code[0];
  assign mag_a = (sgn && bus.a[MSB]) ? -bus.a : bus.a;
  assign mag_b = (sgn && bus.b[MSB]) ? -bus.b : bus.b;

  // Single-cycle ALU decode.
  always_comb begin
    sum_d       = bus.a + bus.b;
    dif_d       = bus.a - bus.b;
    alu_res_d   = '0;
    alu_ovf_d   = 1'b0;
    alu_ill_d   = 1'b0;
    wr_hi_d     = 1'b0;
    wr_lo_d     = 1'b0;
    start_mul_d = 1'b0;
    start_div_d = 1'b0;
    case (bus.func_code)
      F_ADD: begin
        alu_res_d = sum_d;
        alu_ovf_d = (bus.a[MSB] == bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
      end
      F_ADDU: alu_res_d = sum_d;
      F_SUB: begin
        alu_res_d = dif_d;
        alu_ovf_d = (bus.a[MSB] != bus.b[MSB]) && (dif_d[MSB] != bus.a[MSB]);
      end
      F_SUBU:  alu_res_d = dif_d;
      F_AND:   alu_res_d = bus.a & bus.b;
      F_OR:    alu_res_d = bus.a | bus.b;
      F_XOR:   alu_res_d = bus.a ^ bus.b;
      F_NOR:   alu_res_d = ~(bus.a | bus.b);
      F_SLT:   alu_res_d = WIDTH'($signed(bus.a) < $signed(bus.b));
      F_SLTU:  alu_res_d = WIDTH'(bus.a < bus.b);
      F_MFHI:  alu_res_d = hi_q;
      F_MFLO:  alu_res_d = lo_q;
      F_MTHI: begin
        alu_res_d = bus.a;
        wr_hi_d   = 1'b1;
      end
      F_MTLO: begin
        alu_res_d = bus.a;
        wr_lo_d   = 1'b1;
      end
      F_MULT, F_MULTU: start_mul_d = 1'b1;
      F_DIV,  F_DIVU:  start_div_d = 1'b1;
      default: alu_ill_d = 1'b1;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, shift in the quotient bit.
  always_comb begin
    div_cand = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_cand >= {1'b0, opnd_q});
    div_sub  = div_cand[WIDTH-1:0] - opnd_q;
    div_nxt  = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                      : {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Sign correction of the finished magnitudes. Divide-by-zero yields an
  // all-ones quotient; the remainder naturally equals the dividend.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    if (is_mul_q) begin
      fin_hi_d = prod[2*WIDTH-1:WIDTH];
      fin_lo_d = prod[WIDTH-1:0];
    end else begin
      fin_hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fin_lo_d = div0_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
  end

  // Control FSM and all architectural/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      is_mul_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (start_mul_d) begin
              acc_q    <= {{WIDTH{1'b0}}, mag_a};
              opnd_q   <= mag_b;
              neg_q    <= sgn && (bus.a[MSB] ^ bus.b[MSB]);
              negr_q   <= 1'b0;
              div0_q   <= 1'b0;
              is_mul_q <= 1'b1;
              state_q  <= S_MUL;
            end else if (start_div_d) begin
              acc_q    <= {{WIDTH{1'b0}}, mag_a};
              opnd_q   <= mag_b;
              neg_q    <= sgn && (bus.a[MSB] ^ bus.b[MSB]);
              negr_q   <= sgn && bus.a[MSB];
              div0_q   <= (bus.b == '0);
              is_mul_q <= 1'b0;
              state_q  <= S_DIV;
            end else begin
              valid_q  <= 1'b1;
              result_q <= alu_res_d;
              zero_q   <= (alu_res_d == '0);
              ovf_q    <= alu_ovf_d;
              ill_q    <= alu_ill_d;
              if (wr_hi_d) hi_q <= bus.a;
              if (wr_lo_d) lo_q <= bus.a;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_DONE;
        end
        S_DIV: begin
          acc_q <= div_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          hi_q     <= fin_hi_d;
          lo_q     <= fin_lo_d;
          result_q <= fin_lo_d;
          zero_q   <= (fin_lo_d == '0);
          ovf_q    <= 1'b0;
          ill_q    <= 1'b0;
          valid_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv at WIDTH=32 and WIDTH=16.
module tb_alu_muldiv;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(32)) b32 ();
  alu_muldiv_if #(.WIDTH(16)) b16 ();

  alu_muldiv #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  alu_muldiv #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one single-cycle op; returns at the negedge where its result is visible.
  task automatic op32(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    b32.valid_in  = 1'b1;
    b32.func_code = f;
    b32.a         = x;
    b32.b         = y;
    @(negedge clk);
    b32.valid_in  = 1'b0;
  endtask

  // Issue a multi-cycle op; lat = accept edge to valid_out edge, rdy_low = cycles busy.
  task automatic run32(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit poke, output int lat, output int rdy_low);
    lat = -1;
    rdy_low = 0;
    @(negedge clk);
    b32.valid_in  = 1'b1;
    b32.func_code = f;
    b32.a         = x;
    b32.b         = y;
    @(negedge clk);
    b32.valid_in  = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (b32.valid_out) begin
        lat = k - 1;
        break;
      end
      if (!b32.ready_out) rdy_low++;
      if (poke && k == 5) begin
        b32.valid_in  = 1'b1;
        b32.func_code = F_ADD;
        b32.a         = 32'd1;
        b32.b         = 32'd1;
      end
      if (poke && k == 6) b32.valid_in = 1'b0;
      @(negedge clk);
    end
    b32.valid_in = 1'b0;
  endtask

  task automatic run16(input logic [5:0] f, input logic [15:0] x, input logic [15:0] y,
                       output int lat);
    lat = -1;
    @(negedge clk);
    b16.valid_in  = 1'b1;
    b16.func_code = f;
    b16.a         = x;
    b16.b         = y;
    @(negedge clk);
    b16.valid_in  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (b16.valid_out) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rdy;
    int seen;
    b32.valid_in = 1'b0; b32.func_code = '0; b32.a = '0; b32.b = '0;
    b16.valid_in = 1'b0; b16.func_code = '0; b16.a = '0; b16.b = '0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 64'(b32.valid_out), 64'd0);
    check("rst_ready", 64'(b32.ready_out), 64'd1);
    check("rst_result", 64'(b32.result), 64'd0);
    check("rst_hilo", {b32.hi, b32.lo}, 64'd0);

    op32(F_ADD, 32'd5, 32'd7);
    check("add_valid", 64'(b32.valid_out), 64'd1);
    check("add_result", 64'(b32.result), 64'd12);
    check("add_zero", 64'(b32.zero), 64'd0);
    @(negedge clk);
    check("add_pulse", 64'(b32.valid_out), 64'd0);
    check("add_hold", 64'(b32.result), 64'd12);

    op32(F_ADD, 32'h7FFF_FFFF, 32'd1);
    check("addovf_res", 64'(b32.result), 64'h8000_0000);
    check("addovf_flag", 64'(b32.overflow), 64'd1);
    op32(F_ADDU, 32'h7FFF_FFFF, 32'd1);
    check("addu_flag", 64'(b32.overflow), 64'd0);
    op32(F_SUB, 32'h8000_0000, 32'd1);
    check("subovf_flag", 64'(b32.overflow), 64'd1);
    op32(F_SUB, 32'd3, 32'd3);
    check("sub_res", 64'(b32.result), 64'd0);
    check("sub_zero", 64'(b32.zero), 64'd1);

    // Back-to-back single-cycle ops with valid_in held high.
    @(negedge clk);
    b32.valid_in = 1'b1; b32.func_code = F_SLT; b32.a = 32'hFFFF_FFFF; b32.b = 32'd1;
    @(negedge clk);
    check("b2b_slt", {31'd0, b32.valid_out, b32.result}, {31'd0, 1'b1, 32'd1});
    b32.func_code = F_SLTU;
    @(negedge clk);
    check("b2b_sltu", {31'd0, b32.valid_out, b32.result}, {31'd0, 1'b1, 32'd0});
    b32.func_code = F_NOR; b32.a = 32'd0; b32.b = 32'd0;
    @(negedge clk);
    check("b2b_nor", {31'd0, b32.valid_out, b32.result}, {31'd0, 1'b1, 32'hFFFF_FFFF});
    b32.valid_in = 1'b0;

    op32(6'b111111, 32'd9, 32'd9);
    check("ill_flag", 64'(b32.illegal), 64'd1);
    check("ill_res", 64'(b32.result), 64'd0);
    check("ill_valid", 64'(b32.valid_out), 64'd1);

    op32(F_MTHI, 32'h1234, 32'd0);
    op32(F_MTLO, 32'h5678, 32'd0);
    check("mt_hilo", {b32.hi, b32.lo}, {32'h1234, 32'h5678});
    check("mtlo_res", 64'(b32.result), 64'h5678);

    // Asynchronous reset with no clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 64'(b32.result), 64'd0);
    check("arst_hilo", {b32.hi, b32.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run32(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, lat, rdy);
    check("mult_lat", 64'(lat), 64'd33);
    check("mult_busy", 64'(rdy), 64'd33);
    check("mult_hilo", {b32.hi, b32.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    check("mult_res", 64'(b32.result), 64'hFFFF_FFEB);
    @(negedge clk);
    check("mult_after", 64'(b32.valid_out), 64'd0);

    op32(F_MFHI, 32'd0, 32'd0);
    check("mfhi_res", 64'(b32.result), 64'hFFFF_FFFF);

    run32(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, rdy);
    check("div_lat", 64'(lat), 64'd33);
    check("div_hilo", {b32.hi, b32.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run32(F_DIVU, 32'd9, 32'd0, 1'b0, lat, rdy);
    check("divz_hilo", {b32.hi, b32.lo}, {32'd9, 32'hFFFF_FFFF});
    check("divz_ovf", 64'(b32.overflow), 64'd0);
    run32(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, rdy);
    check("divmin_hilo", {b32.hi, b32.lo}, {32'd0, 32'h8000_0000});
    run32(F_DIVU, 32'd100, 32'd7, 1'b0, lat, rdy);
    check("divu_hilo", {b32.hi, b32.lo}, {32'd2, 32'd14});

    // Abort a divide with reset part-way through.
    @(negedge clk);
    b32.valid_in = 1'b1; b32.func_code = F_DIVU; b32.a = 32'd1000; b32.b = 32'd3;
    @(negedge clk);
    b32.valid_in = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy", 64'(b32.ready_out), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_hilo", {b32.hi, b32.lo}, 64'd0);
    check("abort_ready", 64'(b32.ready_out), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b32.valid_out) seen++;
    end
    check("abort_novalid", 64'(seen), 64'd0);
    check("abort_ready2", 64'(b32.ready_out), 64'd1);

    run16(F_MULTU, 16'hFFFF, 16'hFFFF, lat);
    check("w16_lat", 64'(lat), 64'd17);
    check("w16_hilo", 64'({b16.hi, b16.lo}), 64'h0000_0000_FFFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the datapath's R-type ALU.
- Registered output with a valid/ready handshake, signed-overflow and illegal-op flags.
- Adds an iterative multiply/divide unit with architectural HI/LO registers (MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO).
- Sits in the execute stage; the control FSM stalls on ready_out low.

Parameters:
WIDTH, 32, operand/result width in bits (even, >=8)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  operation request
ready_out  output  1  block can accept an operation this cycle
func_code  input  6  MIPS R-type function field
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt
valid_out  output  1  result/flags valid, one-cycle pulse
result  output  WIDTH  operation result
zero  output  1  result == 0, qualified by valid_out
overflow  output  1  signed overflow on ADD/SUB
illegal  output  1  unsupported func_code
hi  output  WIDTH  HI register, always visible
lo  output  WIDTH  LO register, always visible

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; counter clears.
  - valid_out, result, zero, overflow, illegal, hi, lo all clear to 0.
  - ready_out = 1 once rst_n is high.
  - Reset mid-multiply/divide aborts the operation, with no valid_out.
- Handshake:
  - An operation is accepted on a rising edge where valid_in && ready_out.
  - ready_out = (state == IDLE), combinational from state.
  - valid_out never depends combinationally on valid_in.
- Single-cycle ops (accepted in cycle N): result, flags and valid_out are registered at edge N+1. The block stays in IDLE, so one op per cycle is sustained.
  - 100000 ADD: a+b mod 2^WIDTH; overflow = operand signs equal and result sign differs.
  - 100001 ADDU: a+b; overflow = 0.
  - 100010 SUB: a-b; overflow = operand signs differ and result sign != sign of a.
  - 100011 SUBU: a-b; overflow = 0.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise.
  - 101010 SLT: signed a<b, zero-extended to WIDTH. 101011 SLTU: unsigned a<b.
  - 010000 MFHI: result = hi. 010010 MFLO: result = lo.
  - 010001 MTHI: hi <= a, result = a. 010011 MTLO: lo <= a, result = a.
  - Any other code: result = 0, illegal = 1, valid_out still pulses, HI/LO unchanged.
  - overflow/illegal are 0 except where stated above.
- Multi-cycle ops:
  - MULT 011000 / MULTU 011001: IDLE -> MUL.
    - Operands are latched; signed mode latches magnitudes and the product sign.
    - Shift-add, one bit per cycle, for WIDTH cycles, then a DONE cycle.
    - {hi,lo} <= 2*WIDTH-bit product, negated if signed and the signs differ.
  - DIV 011010 / DIVU 011011: IDLE -> DIV. Restoring division for WIDTH cycles, then DONE.
    - lo <= quotient, truncated toward zero. hi <= remainder, taking the sign of the dividend.
    - Divide by zero: lo <= all ones, hi <= a. No other flag.
    - Signed most-negative / -1: lo <= most-negative, hi <= 0.
  - DONE: HI/LO are written, result = new lo, valid_out pulses, state -> IDLE.
  - Accepted at edge N: valid_out is at edge N+WIDTH+1; ready_out is low from N through N+WIDTH.
  - valid_in and operand changes while busy are ignored.
- zero = (registered result == 0); it is meaningful only while valid_out = 1.
- Between valid_out pulses, result, zero, overflow and illegal hold their last values.

Test Plan:
- Reset: drive rst_n low mid-cycle with no clock edge -> all outputs 0 immediately. After release, ADD a=5 b=7 -> next cycle valid_out=1, result=12, zero=0.
- Overflow: ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1. ADDU with the same operands -> overflow=0. SUB a=3 b=3 -> result 0, zero=1.
- Back-to-back: valid_in held high for SLT a=-1 b=1, then SLTU with the same operands, then NOR a=0 b=0 -> results 1, 0, 0xFFFFFFFF on 3 consecutive cycles. Func 111111 -> illegal=1, result 0.
- MULT a=-3 b=7:
  - ready_out low for 33 cycles; valid_out at accept+33.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB; valid_in pulses while busy are ignored.
  - Follow with MFHI -> 0xFFFFFFFF.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=9 b=0 -> lo=0xFFFFFFFF, hi=9. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- Reset abort: start DIVU, assert rst_n low at cycle 10 -> no valid_out, hi=lo=0, ready_out=1 after release. Repeat at WIDTH=16: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 at accept+17.
